rom_dp_arbiter: RTL

//  Shares the two read ports of a dual-port ROM lookup (2-cycle registered read per port) between NREQ requesters.

---
 rtl/rom_dp_arb_pkg.sv | 18 +
 rtl/rom_dp_arbiter_rr_pick.sv | 33 +++
 rtl/rom_dp_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/rom_dp_arb_pkg.sv
// Shared types and helpers for the dual-port ROM read arbiter.
package rom_dp_arb_pkg;

  // Widest requester index the tag pipe has to carry (NREQ up to 16).
  localparam int unsigned TAG_IDX_W = 4;

  // Requester-index width for a given requester count.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Per-port in-flight read tag.
  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/rom_dp_arbiter_rr_pick.sv
// Round-robin finder: first set bit of req at or after ptr (modulo N),
// skipping bits set in mask. Purely combinational.
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] pos;

  // Scan N positions starting at ptr; the first eligible one wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = IDX_W'((32'(ptr) + i) % N);
      if (!found && req[pos] && !mask[pos]) begin
        found    = 1'b1;
        idx      = pos;
        gnt[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rom_dp_arbiter.sv
// Round-robin arbiter sharing the two read ports of a dual-port ROM among
// NREQ requesters, with per-port tag pipes matching the ROM read latency.
// Optional statistics counters: define ROM_DP_ARB_STATS_EN.
module rom_dp_arbiter
  import rom_dp_arb_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 9,
  parameter int unsigned ROM_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       arb_en,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*ADDR_W-1:0]     req_addr,
  output logic [NREQ-1:0]            req_ready,
  output logic [ADDR_W-1:0]          rom_addra,
  output logic [ADDR_W-1:0]          rom_addrb,
  input  logic [DATA_W-1:0]          rom_douta,
  input  logic [DATA_W-1:0]          rom_doutb,
  output logic                       rspa_valid,
  output logic [idx_width(NREQ)-1:0] rspa_idx,
  output logic [DATA_W-1:0]          rspa_data,
  output logic                       rspb_valid,
  output logic [idx_width(NREQ)-1:0] rspb_idx,
  output logic [DATA_W-1:0]          rspb_data
`ifdef ROM_DP_ARB_STATS_EN
  ,
  input  logic                       stat_clr,
  output logic [31:0]                stat_gnt_a,
  output logic [31:0]                stat_gnt_b,
  output logic [31:0]                stat_stall
`endif
);

  localparam int unsigned IDX_W = idx_width(NREQ);

  logic [IDX_W-1:0]  ptr, ptr_next, last_idx;
  logic [NREQ-1:0]   gnt_a, gnt_b, no_mask;
  logic              found_a, found_b;
  logic [IDX_W-1:0]  idx_a, idx_b;
  logic              issue_en, accept_a, accept_b;
  logic [ADDR_W-1:0] addr_a, addr_b;
  tag_t              tag_in_a, tag_in_b;
  tag_t              pipe_a [ROM_LAT+1];
  tag_t              pipe_b [ROM_LAT+1];
  logic              unused_tag_bits;

  assign no_mask = '0;

  rr_pick #(.N(NREQ), .IDX_W(IDX_W)) u_pick_a (
    .req   (req_valid),
    .mask  (no_mask),
    .ptr   (ptr),
    .gnt   (gnt_a),
    .found (found_a),
    .idx   (idx_a)
  );

  // Starting at A's index with A masked out yields "next requester after A".
  rr_pick #(.N(NREQ), .IDX_W(IDX_W)) u_pick_b (
    .req   (req_valid),
    .mask  (gnt_a),
    .ptr   (idx_a),
    .gnt   (gnt_b),
    .found (found_b),
    .idx   (idx_b)
  );

  assign issue_en  = arb_en & rst_n;
  assign accept_a  = issue_en & found_a;
  assign accept_b  = issue_en & found_b;
  assign req_ready = issue_en ? (gnt_a | gnt_b) : '0;

  // Address mux, next pointer and tags entering the pipes.
  always_comb begin
    addr_a = '0;
    addr_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (idx_a == IDX_W'(i)) addr_a = req_addr[i*ADDR_W +: ADDR_W];
      if (idx_b == IDX_W'(i)) addr_b = req_addr[i*ADDR_W +: ADDR_W];
    end
    last_idx       = found_b ? idx_b : idx_a;
    ptr_next       = (last_idx == IDX_W'(NREQ - 1)) ? '0 : last_idx + IDX_W'(1);
    tag_in_a.valid = accept_a;
    tag_in_a.idx   = TAG_IDX_W'(idx_a);
    tag_in_b.valid = accept_b;
    tag_in_b.idx   = TAG_IDX_W'(idx_b);
  end

  // Pointer, registered ROM addresses and tag shift pipes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      rom_addra <= '0;
      rom_addrb <= '0;
      for (int unsigned k = 0; k <= ROM_LAT; k++) begin
        pipe_a[k] <= '0;
        pipe_b[k] <= '0;
      end
    end else begin
      if (accept_a) begin
        ptr       <= ptr_next;
        rom_addra <= addr_a;
      end
      if (accept_b) rom_addrb <= addr_b;
      pipe_a[0] <= tag_in_a;
      pipe_b[0] <= tag_in_b;
      for (int unsigned k = 1; k <= ROM_LAT; k++) begin
        pipe_a[k] <= pipe_a[k-1];
        pipe_b[k] <= pipe_b[k-1];
      end
    end
  end

  assign rspa_valid = pipe_a[ROM_LAT].valid;
  assign rspa_idx   = pipe_a[ROM_LAT].idx[IDX_W-1:0];
  assign rspa_data  = rom_douta;
  assign rspb_valid = pipe_b[ROM_LAT].valid;
  assign rspb_idx   = pipe_b[ROM_LAT].idx[IDX_W-1:0];
  assign rspb_data  = rom_doutb;

  assign unused_tag_bits = ^{pipe_a[ROM_LAT].idx, pipe_b[ROM_LAT].idx};

`ifdef ROM_DP_ARB_STATS_EN
  // Saturating accept / contention counters; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_gnt_a <= '0;
      stat_gnt_b <= '0;
      stat_stall <= '0;
    end else if (stat_clr) begin
      stat_gnt_a <= '0;
      stat_gnt_b <= '0;
      stat_stall <= '0;
    end else begin
      if (accept_a && stat_gnt_a != '1) stat_gnt_a <= stat_gnt_a + 32'd1;
      if (accept_b && stat_gnt_b != '1) stat_gnt_b <= stat_gnt_b + 32'd1;
      if (arb_en && ($countones(req_valid) > 2) && stat_stall != '1)
        stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule
